// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data memory between the processor load/store path (CPU
// port) and the debug/loader path (DBG port). At most one access is granted
// per cycle. The winner's address and write data are steered onto the memory
// bus, and the memory's read/write enables are driven from the winner's
// request. Load data is registered into the winning port's rdata register,
// together with a one-cycle rvalid strobe. The debug port can lock the memory
// for back-to-back accesses. While locked, the CPU is held off and sees
// cpu_stall.
//
// Optional feature (compile-time macro):
//   DMEM_ARB_ROUND_ROBIN_EN
//     Defined   : on a conflict in ARB, the port that was not granted last
//                 wins. prio tracks the last ARB-state grant.
//     Undefined : fixed priority, and the CPU always wins conflicts. prio is
//                 held at its reset value.
//
// Parameters
//   xlen            data and address width in bits
//
// Ports
//   clk             system clock, rising-edge active
//   rst             synchronous active-high reset
//   cpu_req/we/addr/wdata   CPU access request (held until cpu_gnt)
//   cpu_gnt         CPU access performed this cycle
//   cpu_rvalid      one-cycle strobe, cpu_rdata valid
//   cpu_rdata       registered CPU load data
//   cpu_stall       cpu_req & ~cpu_gnt
//   dbg_req/we/addr/wdata   DBG access request (held until dbg_gnt)
//   dbg_lock        DBG requests exclusive ownership while high
//   dbg_gnt/rvalid/rdata    DBG counterparts of the CPU outputs
//   mem_read_en     data memory read enable
//   mem_write_en    data memory write enable
//   mem_address     data memory address
//   mem_write_data  data memory write data
//   mem_read_data   combinational read data from the data memory
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int xlen = 64
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [xlen-1:0] cpu_addr,
    input  logic [xlen-1:0] cpu_wdata,
    output logic            cpu_gnt,
    output logic            cpu_rvalid,
    output logic [xlen-1:0] cpu_rdata,
    output logic            cpu_stall,

    input  logic            dbg_req,
    input  logic            dbg_we,
    input  logic [xlen-1:0] dbg_addr,
    input  logic [xlen-1:0] dbg_wdata,
    input  logic            dbg_lock,
    output logic            dbg_gnt,
    output logic            dbg_rvalid,
    output logic [xlen-1:0] dbg_rdata,

    output logic            mem_read_en,
    output logic            mem_write_en,
    output logic [xlen-1:0] mem_address,
    output logic [xlen-1:0] mem_write_data,
    input  logic [xlen-1:0] mem_read_data
);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef enum logic {
        PRIO_CPU = 1'b0,
        PRIO_DBG = 1'b1
    } prio_t;

    state_t            state_q;
    prio_t             prio_q;

    logic              cpu_gnt_c;
    logic              dbg_gnt_c;
    logic              cpu_load;
    logic              dbg_load;

    logic              cpu_rvalid_q;
    logic              dbg_rvalid_q;
    logic [xlen-1:0]   cpu_rdata_q;
    logic [xlen-1:0]   dbg_rdata_q;

    // Grant decision. This is purely combinational from the requests and the
    // registered state, so a winning port is served in the cycle it asks.
    // Reset forces every grant low, which also keeps the memory idle. In
    // LOCKED the debug port owns the memory outright, and the CPU is shut out
    // even when the debug port has nothing to do that cycle.
    always_comb begin
        cpu_gnt_c = 1'b0;
        dbg_gnt_c = 1'b0;
        if (!rst) begin
            if (state_q == LOCKED) begin
                dbg_gnt_c = dbg_req;
            end else if (cpu_req && dbg_req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                // prio remembers who won last, so the other port wins now.
                cpu_gnt_c = (prio_q == PRIO_DBG);
                dbg_gnt_c = (prio_q == PRIO_CPU);
`else
                cpu_gnt_c = 1'b1;
                dbg_gnt_c = 1'b0;
`endif
            end else begin
                cpu_gnt_c = cpu_req;
                dbg_gnt_c = dbg_req;
            end
        end
    end

    assign cpu_gnt   = cpu_gnt_c;
    assign dbg_gnt   = dbg_gnt_c;
    assign cpu_stall = cpu_req & ~cpu_gnt_c;

    assign cpu_load  = cpu_gnt_c & ~cpu_we;
    assign dbg_load  = dbg_gnt_c & ~dbg_we;

    // Memory bus steering. The grants are one-hot or zero, so the enables
    // can be OR-ed from the per-port terms. An idle bus drives zeros rather
    // than leaking a stalled port's address onto the memory.
    always_comb begin
        mem_read_en    = cpu_load | dbg_load;
        mem_write_en   = (cpu_gnt_c & cpu_we) | (dbg_gnt_c & dbg_we);
        mem_address    = '0;
        mem_write_data = '0;
        if (cpu_gnt_c) begin
            mem_address    = cpu_addr;
            mem_write_data = cpu_wdata;
        end else if (dbg_gnt_c) begin
            mem_address    = dbg_addr;
            mem_write_data = dbg_wdata;
        end
    end

    // Control FSM plus the round-robin pointer. The lock is only taken by an
    // ARB-state debug grant with dbg_lock high, so raising dbg_lock without a
    // request does nothing. The lock is released at the first edge that sees
    // dbg_lock low, and that last locked cycle still serves a debug request.
    // prio only moves on ARB-state grants, so accesses made under a lock do
    // not disturb the fairness history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            prio_q  <= PRIO_CPU;
        end else begin
            case (state_q)
                ARB: begin
                    if (dbg_gnt_c && dbg_lock) begin
                        state_q <= LOCKED;
                    end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                    if (cpu_gnt_c) begin
                        prio_q <= PRIO_CPU;
                    end else if (dbg_gnt_c) begin
                        prio_q <= PRIO_DBG;
                    end
`else
                    prio_q <= PRIO_CPU;
`endif
                end
                LOCKED: begin
                    if (!dbg_lock) begin
                        state_q <= ARB;
                    end
                end
                default: begin
                    state_q <= ARB;
                end
            endcase
        end
    end

    // Read return path. A granted load captures the memory's combinational
    // read data at the grant edge and raises that port's rvalid for the
    // following cycle only. rdata is left alone otherwise, so it keeps the
    // last loaded value. Back-to-back loads simply keep rvalid high with
    // fresh data each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            cpu_rvalid_q <= cpu_load;
            dbg_rvalid_q <= dbg_load;
            if (cpu_load) begin
                cpu_rdata_q <= mem_read_data;
            end
            if (dbg_load) begin
                dbg_rdata_q <= mem_read_data;
            end
        end
    end

    // A reset arriving in the cycle after a granted load must swallow the
    // strobe that is already sitting in the register, so gate it here.
    assign cpu_rvalid = cpu_rvalid_q & ~rst;
    assign dbg_rvalid = dbg_rvalid_q & ~rst;
    assign cpu_rdata  = cpu_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;

    // Structural invariants of the arbiter.
    a_one_grant : assert property (@(posedge clk) !(cpu_gnt_c && dbg_gnt_c));
    a_one_enable : assert property (@(posedge clk) !(mem_read_en && mem_write_en));
    a_no_cpu_in_lock : assert property (@(posedge clk) disable iff (rst)
        (state_q == LOCKED) |-> !cpu_gnt_c);
    a_cpu_rvalid_src : assert property (@(posedge clk) disable iff (rst)
        cpu_rvalid_q |-> $past(cpu_load));
    a_dbg_rvalid_src : assert property (@(posedge clk) disable iff (rst)
        dbg_rvalid_q |-> $past(dbg_load));
`ifndef DMEM_ARB_ROUND_ROBIN_EN
    a_prio_held : assert property (@(posedge clk) disable iff (rst)
        prio_q == PRIO_CPU);
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter. It drives a directed table with
// hand-derived grant expectations, followed by randomized mixed traffic. A
// reference model tracks the arbiter state, the priority pointer and a shadow
// memory. Expected load data is queued per port when a load is granted, and
// popped when the port's rvalid is due. A small behavioural data memory sits
// on the mem_* bus.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            cpu_req, cpu_we;
    logic [XLEN-1:0] cpu_addr, cpu_wdata;
    logic            cpu_gnt, cpu_rvalid, cpu_stall;
    logic [XLEN-1:0] cpu_rdata;
    logic            dbg_req, dbg_we, dbg_lock;
    logic [XLEN-1:0] dbg_addr, dbg_wdata;
    logic            dbg_gnt, dbg_rvalid;
    logic [XLEN-1:0] dbg_rdata;
    logic            mem_read_en, mem_write_en;
    logic [XLEN-1:0] mem_address, mem_write_data, mem_read_data;

    int tests = 0;
    int fails = 0;

    dmem_arbiter #(.xlen(XLEN)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: 16 doublewords, combinational read.
    logic [XLEN-1:0] dmem [16];
    assign mem_read_data = dmem[mem_address[6:3]];
    always @(posedge clk) begin
        if (mem_write_en) dmem[mem_address[6:3]] <= mem_write_data;
    end

    typedef struct {
        logic            rst;
        logic            cpu_req, cpu_we;
        logic [XLEN-1:0] cpu_addr, cpu_wdata;
        logic            dbg_req, dbg_we;
        logic [XLEN-1:0] dbg_addr, dbg_wdata;
        logic            dbg_lock;
        logic            exp_cpu_gnt, exp_dbg_gnt;
    } vec_t;

    // Reference model state.
    logic            m_locked;
    logic            m_prio_dbg;
    logic [XLEN-1:0] ref_mem [16];
    logic [XLEN-1:0] cpu_q[$];
    logic [XLEN-1:0] dbg_q[$];
    logic [XLEN-1:0] cpu_hold, dbg_hold;
    logic            m_cpu_gnt, m_dbg_gnt;

    function automatic vec_t mk(logic r, logic cr, logic cw, logic [XLEN-1:0] ca,
                                logic [XLEN-1:0] cd, logic dr, logic dw,
                                logic [XLEN-1:0] da, logic [XLEN-1:0] dd, logic dl,
                                logic ecg, logic edg);
        vec_t v;
        v.rst = r; v.cpu_req = cr; v.cpu_we = cw; v.cpu_addr = ca; v.cpu_wdata = cd;
        v.dbg_req = dr; v.dbg_we = dw; v.dbg_addr = da; v.dbg_wdata = dd; v.dbg_lock = dl;
        v.exp_cpu_gnt = ecg; v.exp_dbg_gnt = edg;
        return v;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [XLEN-1:0] act,
                              input logic [XLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        rst = v.rst;
        cpu_req = v.cpu_req; cpu_we = v.cpu_we; cpu_addr = v.cpu_addr; cpu_wdata = v.cpu_wdata;
        dbg_req = v.dbg_req; dbg_we = v.dbg_we; dbg_addr = v.dbg_addr; dbg_wdata = v.dbg_wdata;
        dbg_lock = v.dbg_lock;
    endtask

    // Compares the current cycle's outputs against the model. Called mid-cycle.
    task automatic check_output();
        logic            exp_cv, exp_dv;
        logic [XLEN-1:0] exp_addr, exp_wd;
        m_cpu_gnt = 1'b0;
        m_dbg_gnt = 1'b0;
        if (!rst) begin
            if (m_locked) begin
                m_dbg_gnt = dbg_req;
            end else if (cpu_req && dbg_req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                m_cpu_gnt = m_prio_dbg;
                m_dbg_gnt = !m_prio_dbg;
`else
                m_cpu_gnt = 1'b1;
`endif
            end else begin
                m_cpu_gnt = cpu_req;
                m_dbg_gnt = dbg_req;
            end
        end
        check_bit("cpu_gnt", cpu_gnt, m_cpu_gnt);
        check_bit("dbg_gnt", dbg_gnt, m_dbg_gnt);
        check_bit("cpu_stall", cpu_stall, cpu_req & ~m_cpu_gnt);
        check_bit("mem_write_en", mem_write_en, (m_cpu_gnt & cpu_we) | (m_dbg_gnt & dbg_we));
        check_bit("mem_read_en", mem_read_en, (m_cpu_gnt & ~cpu_we) | (m_dbg_gnt & ~dbg_we));
        exp_addr = m_cpu_gnt ? cpu_addr : (m_dbg_gnt ? dbg_addr : '0);
        exp_wd   = m_cpu_gnt ? cpu_wdata : (m_dbg_gnt ? dbg_wdata : '0);
        check_word("mem_address", mem_address, exp_addr);
        check_word("mem_write_data", mem_write_data, exp_wd);
        check_bit("one_grant", cpu_gnt & dbg_gnt, 1'b0);
        check_bit("one_enable", mem_read_en & mem_write_en, 1'b0);

        exp_cv = (cpu_q.size() > 0) && !rst;
        exp_dv = (dbg_q.size() > 0) && !rst;
        check_bit("cpu_rvalid", cpu_rvalid, exp_cv);
        check_bit("dbg_rvalid", dbg_rvalid, exp_dv);
        if (!rst) begin
            if (exp_cv) cpu_hold = cpu_q.pop_front();
            if (exp_dv) dbg_hold = dbg_q.pop_front();
            check_word("cpu_rdata", cpu_rdata, cpu_hold);
            check_word("dbg_rdata", dbg_rdata, dbg_hold);
        end
    endtask

    // Advances the model across the coming clock edge.
    task automatic model_update();
        if (rst) begin
            m_locked = 1'b0;
            m_prio_dbg = 1'b0;
            cpu_q.delete();
            dbg_q.delete();
            cpu_hold = '0;
            dbg_hold = '0;
        end else begin
            if (m_cpu_gnt) begin
                if (cpu_we) ref_mem[cpu_addr[6:3]] = cpu_wdata;
                else cpu_q.push_back(ref_mem[cpu_addr[6:3]]);
            end
            if (m_dbg_gnt) begin
                if (dbg_we) ref_mem[dbg_addr[6:3]] = dbg_wdata;
                else dbg_q.push_back(ref_mem[dbg_addr[6:3]]);
            end
            if (!m_locked) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                if (m_cpu_gnt) m_prio_dbg = 1'b0;
                else if (m_dbg_gnt) m_prio_dbg = 1'b1;
`endif
                if (m_dbg_gnt && dbg_lock) m_locked = 1'b1;
            end else if (!dbg_lock) begin
                m_locked = 1'b0;
            end
        end
    endtask

    task automatic run_cycle(input vec_t v, input bit use_table, input int idx);
        apply_stimulus(v);
        @(negedge clk);
        check_output();
        if (use_table) begin
            check_bit($sformatf("table[%0d].cpu_gnt", idx), cpu_gnt, v.exp_cpu_gnt);
            check_bit($sformatf("table[%0d].dbg_gnt", idx), dbg_gnt, v.exp_dbg_gnt);
        end
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        logic rr;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        for (int i = 0; i < 16; i++) begin
            dmem[i] = '0;
            ref_mem[i] = '0;
        end
        m_locked = 1'b0; m_prio_dbg = 1'b0; cpu_hold = '0; dbg_hold = '0;
        m_cpu_gnt = 1'b0; m_dbg_gnt = 1'b0;

        //          rst cr cw caddr   cwdata   dr dw daddr   dwdata   lk  ecg   edg
        tbl.push_back(mk(1, 1, 0, 64'h10, 64'h0,    1, 0, 64'h20, 64'h0,    1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 64'h0,  64'h0,    0, 0, 64'h0,  64'h0,    0, 0, 0));
        // CPU store then load of 0x10; data returns on the idle cycle after.
        tbl.push_back(mk(0, 1, 1, 64'h10, 64'hDEAD, 0, 0, 64'h0,  64'h0,    0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 64'h10, 64'h0,    0, 0, 64'h0,  64'h0,    0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 64'h0,  64'h0,    0, 0, 64'h0,  64'h0,    0, 0, 0));
        // Lone DBG store, leaves the round-robin pointer at DBG.
        tbl.push_back(mk(0, 0, 0, 64'h0,  64'h0,    1, 1, 64'h20, 64'h1234, 0, 0, 1));
        // Four cycles of conflicting loads.
        for (int i = 0; i < 4; i++) begin
            logic cw = rr ? (i % 2 == 0) : 1'b1;
            tbl.push_back(mk(0, 1, 0, 64'h10, 64'h0, 1, 0, 64'h20, 64'h0, 0, cw, ~cw));
        end
        tbl.push_back(mk(0, 0, 0, 64'h0,  64'h0,    0, 0, 64'h0,  64'h0,    0, 0, 0));
        // Lock taken by a lone DBG store, then three locked stores against a waiting CPU.
        tbl.push_back(mk(0, 0, 0, 64'h0,  64'h0,    1, 1, 64'h28, 64'hA0,   1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 64'h20, 64'h0,    1, 1, 64'h30, 64'hA1,   1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 64'h20, 64'h0,    1, 1, 64'h38, 64'hA2,   1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 64'h20, 64'h0,    1, 1, 64'h40, 64'hA3,   1, 0, 1));
        // Lock dropped: the DBG request is still served in that cycle, then the CPU wins.
        tbl.push_back(mk(0, 1, 0, 64'h20, 64'h0,    1, 1, 64'h48, 64'hA4,   0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 64'h20, 64'h0,    1, 0, 64'h30, 64'h0,    0, 1, 0));
        // dbg_lock without dbg_req has no effect.
        tbl.push_back(mk(0, 0, 0, 64'h0,  64'h0,    0, 0, 64'h0,  64'h0,    1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 64'h38, 64'h0,    0, 0, 64'h0,  64'h0,    1, 1, 0));
        // Locked DBG load, then reset in the next cycle, then CPU is served in ARB.
        tbl.push_back(mk(0, 0, 0, 64'h0,  64'h0,    1, 0, 64'h10, 64'h0,    1, 0, 1));
        tbl.push_back(mk(1, 1, 0, 64'h10, 64'h0,    0, 0, 64'h0,  64'h0,    1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 64'h48, 64'h0,    0, 0, 64'h0,  64'h0,    0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 64'h0,  64'h0,    0, 0, 64'h0,  64'h0,    0, 0, 0));

        #1;
        foreach (tbl[i]) run_cycle(tbl[i], 1'b1, i);

        // Randomized mixed traffic.
        for (int n = 0; n < 400; n++) begin
            v.rst       = ($urandom_range(0, 63) == 0);
            v.cpu_req   = ($urandom_range(0, 9) < 7);
            v.cpu_we    = $urandom_range(0, 1);
            v.cpu_addr  = {57'd0, 4'($urandom_range(0, 15)), 3'b000};
            v.cpu_wdata = {$urandom, $urandom};
            v.dbg_req   = ($urandom_range(0, 1) == 1);
            v.dbg_we    = $urandom_range(0, 1);
            v.dbg_addr  = {57'd0, 4'($urandom_range(0, 15)), 3'b000};
            v.dbg_wdata = {$urandom, $urandom};
            v.dbg_lock  = ($urandom_range(0, 3) == 0);
            v.exp_cpu_gnt = 1'b0;
            v.exp_dbg_gnt = 1'b0;
            run_cycle(v, 1'b0, n);
        end
        v = mk(0, 0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 0, 0, 0);
        run_cycle(v, 1'b0, 0);
        run_cycle(v, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
